mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/arb_prio2.sv | 15 +
 rtl/mem_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W       = 32;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_STARVE_LIMIT = 4;
  localparam int unsigned STARVE_CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_DM = 2'd2
  } resp_state_e;

endpackage

// File: rtl/arb_prio2.sv
// Two-input fixed-priority selector; force_lo lets the low-priority side win for one cycle.
module arb_prio2 (
  input  logic hi_req,
  input  logic lo_req,
  input  logic force_lo,
  output logic hi_gnt,
  output logic lo_gnt
);

  always_comb begin
    lo_gnt = lo_req && (force_lo || !hi_req);
    hi_gnt = hi_req && !lo_gnt;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port memory with 1-cycle read latency.
// Optional starvation guard for fetch enabled by MEM_ARBITER_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  resp_state_e state_q;
  resp_state_e state_next;
  logic        if_gnt;
  logic        dm_gnt;
  logic        force_if;

  // Requests are masked while reset is low so no strobe or ready leaks out.
  arb_prio2 u_prio (
    .hi_req  (dm_req && reset),
    .lo_req  (if_req && reset),
    .force_lo(force_if),
    .hi_gnt  (dm_gnt),
    .lo_gnt  (if_gnt)
  );

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  logic [STARVE_CNT_W-1:0] starve_cnt;

  always_ff @(posedge clock) begin
    if (!reset || !if_req || if_gnt) starve_cnt <= '0;
    else                             starve_cnt <= starve_cnt + 1'b1;
  end

  assign force_if = (starve_cnt == STARVE_CNT_W'(STARVE_LIMIT));
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    if_ready  = if_gnt;
    dm_ready  = dm_gnt;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_ren  = 1'b1;
      mem_addr = if_addr;
    end else if (dm_gnt) begin
      mem_ren   = !dm_we;
      mem_wen   = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end
  end

  always_comb begin
    state_next = IDLE;
    if (if_gnt)               state_next = RESP_IF;
    else if (dm_gnt && !dm_we) state_next = RESP_DM;
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_next;
  end

  // A response in flight when reset drops is suppressed immediately.
  always_comb begin
    if_rvalid = reset && (state_q == RESP_IF);
    dm_rvalid = reset && (state_q == RESP_DM);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = dm_rvalid ? mem_rdata : '0;
  end

endmodule
